// File: rtl/chunked_add_sub.sv
// Purpose : N-bit add/subtract computed W bits per cycle, LSB chunk first, carry rippled through a register.
// Latency : done pulses K=N/W cycles after the accepted start edge; one operation per K+1 cycles.
// Backpr. : no queueing; start is only honoured while busy=0, and start during busy is dropped.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   start, sub      - begin an operation (0: num1+num2, 1: num1-num2), sampled when idle
//   num1, num2      - N-bit operands, sampled with start
//   busy, done      - busy while chunks run; done is a one-cycle pulse as results update
//   sum, carry      - result modulo 2^N and carry out of bit N-1 (1 = no borrow when subtracting)
//   overflow        - two's-complement signed overflow of the operation
module chunked_add_sub #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sub,
   input  logic [N-1:0] num1,
   input  logic [N-1:0] num2,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         carry,
   output logic         overflow
);

   localparam int K  = N / W;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   if (N < 1 || W < 1 || W > N || (N % W) != 0) begin : g_bad_params
      $error("chunked_add_sub: need N >= 1, 1 <= W <= N and N a multiple of W");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    a_q, b_q, acc;
   logic            cy_q;
   logic [CW-1:0]   cnt;

   logic [W-1:0]    a_ch, b_ch;
   logic [W:0]      csum;
   logic [N-1:0]    acc_nxt;
   logic            last;
   logic            c_top;

   assign busy = (state_q == RUN);
   assign last = (cnt == CW'(K - 1));

   // Chunk select and accumulator write use a compare-per-chunk mux so every
   // index is a constant; the counter never has to be widened into a bit offset.
   always_comb begin
      a_ch    = '0;
      b_ch    = '0;
      acc_nxt = acc;
      for (int k = 0; k < K; k++) begin
         if (cnt == CW'(k)) begin
            a_ch = a_q[k*W +: W];
            b_ch = b_q[k*W +: W];
         end
      end
      csum = {1'b0, a_ch} + {1'b0, b_ch} + {{W{1'b0}}, cy_q};
      for (int k = 0; k < K; k++) begin
         if (cnt == CW'(k)) begin
            acc_nxt[k*W +: W] = csum[W-1:0];
         end
      end
   end

   // Carry into the chunk's top bit, recovered from that bit's sum and inputs
   // (s = a ^ b ^ cin); on the last chunk this is the carry into bit N-1.
   assign c_top = csum[W-1] ^ a_ch[W-1] ^ b_ch[W-1];

   always_comb begin
      state_d = state_q;
      if (state_q == IDLE) begin
         if (start) state_d = RUN;
      end else begin
         if (last) state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
         cy_q     <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= 1'b0;
         if (state_q == IDLE) begin
            if (start) begin
               // Subtraction is A + ~B + 1: invert B here, seed the carry with sub.
               a_q  <= num1;
               b_q  <= num2 ^ {N{sub}};
               cy_q <= sub;
               cnt  <= '0;
            end
         end else begin
            acc  <= acc_nxt;
            cy_q <= csum[W];
            cnt  <= cnt + 1'b1;
            if (last) begin
               sum      <= acc_nxt;
               carry    <= csum[W];
               overflow <= c_top ^ csum[W];
               done     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_chunked_add_sub.sv
module tb_chunked_add_sub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  st = '0, sb = '0;
   logic [15:0] na[3], nb[3];
   logic [2:0]  bz, dn, cy, ov;
   logic [15:0] sm[3];
   logic [4:0]  s1, s2;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // instance 0: N=16 W=4 (K=4); instance 1: N=5 W=5 (K=1); instance 2: N=5 W=1 (K=5)
   int NP[3] = '{16, 5, 5};
   int KP[3] = '{4, 1, 5};

   always #5 clk = ~clk;

   chunked_add_sub #(.N(16), .W(4)) u0 (
      .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]), .num1(na[0]), .num2(nb[0]),
      .busy(bz[0]), .done(dn[0]), .sum(sm[0]), .carry(cy[0]), .overflow(ov[0]));

   chunked_add_sub #(.N(5), .W(5)) u1 (
      .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]), .num1(na[1][4:0]), .num2(nb[1][4:0]),
      .busy(bz[1]), .done(dn[1]), .sum(s1), .carry(cy[1]), .overflow(ov[1]));

   chunked_add_sub #(.N(5), .W(1)) u2 (
      .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]), .num1(na[2][4:0]), .num2(nb[2][4:0]),
      .busy(bz[2]), .done(dn[2]), .sum(s2), .carry(cy[2]), .overflow(ov[2]));

   assign sm[1] = {11'b0, s1};
   assign sm[2] = {11'b0, s2};

   // Arithmetic reference: result of the whole N-bit operation from integer maths.
   function automatic void refop(input int n, input logic s, input logic [15:0] x, input logic [15:0] y,
                                 output logic [15:0] rs, output logic rc, output logic ro);
      longint m, xx, yy, t, sx, sy, r;
      m  = longint'(1) << n;
      xx = longint'({48'b0, x}) & (m - 1);
      yy = longint'({48'b0, y}) & (m - 1);
      if (s) begin
         t  = xx - yy + m;
         rc = (xx >= yy);
      end else begin
         t  = xx + yy;
         rc = (t >= m);
      end
      rs = 16'(t % m);
      sx = (xx >= m / 2) ? xx - m : xx;
      sy = (yy >= m / 2) ? yy - m : yy;
      r  = s ? sx - sy : sx + sy;
      ro = (r < -(m / 2)) || (r >= m / 2);
   endfunction

   // Transaction-level model: an accepted start yields its result K edges later.
   int          rem[3];
   logic [15:0] msum[3], psum[3];
   logic        mc[3], mo[3], mbusy[3], mdone[3], pc[3], po[3];

   initial begin
      for (int d = 0; d < 3; d++) begin
         rem[d] = 0; msum[d] = '0; psum[d] = '0;
         mc[d] = 0; mo[d] = 0; mbusy[d] = 0; mdone[d] = 0; pc[d] = 0; po[d] = 0;
         na[d] = '0; nb[d] = '0;
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            rem[d] = 0; msum[d] = '0; mc[d] = 0; mo[d] = 0; mbusy[d] = 0; mdone[d] = 0;
         end else if (rem[d] > 0) begin
            rem[d]--;
            if (rem[d] == 0) begin
               mdone[d] = 1; mbusy[d] = 0;
               msum[d] = psum[d]; mc[d] = pc[d]; mo[d] = po[d];
            end
         end else begin
            mdone[d] = 0;
            if (st[d]) begin
               refop(NP[d], sb[d], na[d], nb[d], psum[d], pc[d], po[d]);
               rem[d] = KP[d];
               mbusy[d] = 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("busy%0d", d), 32'(bz[d]), 32'(mbusy[d]));
            chk($sformatf("done%0d", d), 32'(dn[d]), 32'(mdone[d]));
            chk($sformatf("sum%0d", d), 32'(sm[d]), 32'(msum[d]));
            chk($sformatf("carry%0d", d), 32'(cy[d]), 32'(mc[d]));
            chk($sformatf("ovf%0d", d), 32'(ov[d]), 32'(mo[d]));
         end
      end
   end

   task automatic go(input int d, input logic s, input logic [15:0] x, input logic [15:0] y);
      st[d] = 1'b1; sb[d] = s; na[d] = x; nb[d] = y;
      @(posedge clk); #1;
      st[d] = 1'b0; na[d] = 16'($urandom); nb[d] = 16'($urandom);
   endtask

   task automatic wait_done(input int d, input int maxc, output int cyc);
      cyc = -1;
      for (int c = 1; c <= maxc; c++) begin
         @(posedge clk); #1;
         if (dn[d] === 1'b1) begin
            cyc = c;
            return;
         end
      end
      total++; bad++;
      $display("FAIL timeout%0d: no done within %0d cycles", d, maxc);
   endtask

   task automatic op_lit(input string nm, input int d, input logic s, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] es, input logic ec,
                         input logic eo, input int ecyc);
      int cyc;
      go(d, s, x, y);
      wait_done(d, 20, cyc);
      chk({nm, "_lat"}, 32'(cyc), 32'(ecyc));
      chk({nm, "_sum"}, 32'(sm[d]), 32'(es));
      chk({nm, "_c"}, 32'(cy[d]), 32'(ec));
      chk({nm, "_o"}, 32'(ov[d]), 32'(eo));
      @(posedge clk); #1;
   endtask

   initial begin
      int cyc, nd;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_en = 1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_busy", 32'(bz[0]), 0);
      chk("rst_sum", 32'(sm[0]), 0);
      chk("rst_done", 32'(dn[0]), 0);

      op_lit("add9_7",   0, 0, 16'd9,      16'd7,      16'd16,     0, 0, 4);
      op_lit("addffff",  0, 0, 16'hFFFF,   16'h0001,   16'h0000,   1, 0, 4);
      op_lit("add7fff",  0, 0, 16'h7FFF,   16'h0001,   16'h8000,   0, 1, 4);
      op_lit("sub3_12",  0, 1, 16'd3,      16'd12,     16'hFFF7,   0, 0, 4);
      op_lit("sub8000",  0, 1, 16'h8000,   16'h0001,   16'h7FFF,   1, 1, 4);
      op_lit("n5w5",     1, 0, 16'd9,      16'd7,      16'h0010,   0, 1, 1);
      op_lit("n5w1",     2, 0, 16'h0017,   16'd7,      16'h001E,   0, 0, 5);

      // start while busy is dropped
      go(0, 0, 16'd9, 16'd7);
      @(posedge clk); #1;
      st[0] = 1'b1; na[0] = 16'd1; nb[0] = 16'd1;
      @(posedge clk); #1;
      st[0] = 1'b0;
      wait_done(0, 10, cyc);
      chk("ign_lat", 32'(cyc), 2);
      chk("ign_sum", 32'(sm[0]), 16);
      @(posedge clk); #1;

      // reset together with a start at E2 aborts the operation
      go(0, 0, 16'd9, 16'd7);
      @(posedge clk); #1;
      rst = 1'b1; st[0] = 1'b1; na[0] = 16'd1; nb[0] = 16'd1;
      @(posedge clk); #1;
      rst = 1'b0; st[0] = 1'b0;
      chk("abort_busy", 32'(bz[0]), 0);
      chk("abort_sum", 32'(sm[0]), 0);
      chk("abort_c", 32'(cy[0]), 0);
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (dn[0] === 1'b1) nd++;
      end
      chk("abort_nodone", 32'(nd), 0);
      op_lit("after_rst", 0, 1, 16'd100,   16'd58,     16'd42,     1, 0, 4);

      // start held high restarts every K+1 edges
      st[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         na[0] = 16'($urandom); nb[0] = 16'($urandom); sb[0] = 1'($urandom);
         @(posedge clk); #1;
      end
      st[0] = 1'b0;

      // random traffic on all instances with occasional resets
      for (int i = 0; i < 3000; i++) begin
         for (int d = 0; d < 3; d++) begin
            st[d] = ($urandom_range(0, 2) == 0);
            sb[d] = 1'($urandom);
            na[d] = 16'($urandom);
            nb[d] = 16'($urandom);
         end
         rst = ($urandom_range(0, 199) == 0);
         @(posedge clk); #1;
      end
      st = '0; rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
